// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode constants and sequencer state encoding for alu32_seq_ctrl
package alu_seq_pkg;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;
endpackage

// File: rtl/alu_seq_opdec.sv
// alu_seq_opdec: decodes a request opcode into legality, class, ALU opcode and first-pass carry-in
module alu_seq_opdec
    import alu_seq_pkg::*;
(
    input  logic [2:0] i_op,
    output logic       o_legal,
    output logic       o_is_arith,
    output logic       o_is_slt,
    output logic [2:0] o_alu_op,
    output logic       o_cin0
);
    // SLT runs on the ALU as SUB; illegal codes never reach the ALU
    always_comb begin
        o_is_slt   = (i_op == OP_SLT);
        o_is_arith = (i_op == OP_ADD) | (i_op == OP_SUB);
        o_legal    = o_is_slt | o_is_arith | (i_op == OP_AND) | (i_op == OP_OR);
        o_alu_op   = o_is_slt ? OP_SUB : (o_legal ? i_op : OP_AND);
        o_cin0     = o_legal & i_op[2];
    end
endmodule

// File: rtl/alu32_seq_ctrl.sv
// alu32_seq_ctrl: runs 32-bit ops as two carry-chained passes on a shared 16-bit ALU
// Optional op counter enabled by defining ALU_SEQ_PERF_CNT_EN.
module alu32_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int HALF  = 16,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [2*HALF-1:0] req_a,
    input  logic [2*HALF-1:0] req_b,
    output logic [HALF-1:0]   alu_a,
    output logic [HALF-1:0]   alu_b,
    output logic              alu_cin,
    output logic              alu_less,
    output logic [2:0]        alu_op,
    input  logic [HALF-1:0]   alu_result,
    input  logic              alu_cout,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [2*HALF-1:0] resp_result,
    output logic              resp_cout,
    output logic              resp_zero,
    output logic              resp_ovf,
    output logic              resp_illegal,
    output logic [CNT_W-1:0]  op_count
);
    state_t            r_state, w_next;
    logic [2*HALF-1:0] r_a, r_b, r_res;
    logic [2:0]        r_alu_op, w_alu_op;
    logic              r_cin0, r_arith, r_slt, r_illegal;
    logic              r_cout_lo, r_zero_lo, r_zero_hi, r_cout, r_ovf;
    logic              w_legal, w_arith, w_slt, w_cin0;
    logic              w_lo, w_hi, w_done, w_slt_bit, w_req_hs;

    alu_seq_opdec u_dec (
        .i_op       (req_op),
        .o_legal    (w_legal),
        .o_is_arith (w_arith),
        .o_is_slt   (w_slt),
        .o_alu_op   (w_alu_op),
        .o_cin0     (w_cin0)
    );

    // state, latched request and per-pass result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_alu_op  <= '0;
            r_cin0    <= 1'b0;
            r_arith   <= 1'b0;
            r_slt     <= 1'b0;
            r_illegal <= 1'b0;
            r_cout_lo <= 1'b0;
            r_zero_lo <= 1'b0;
            r_zero_hi <= 1'b0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_req_hs) begin
                r_a       <= req_a;
                r_b       <= req_b;
                r_alu_op  <= w_alu_op;
                r_cin0    <= w_cin0;
                r_arith   <= w_arith;
                r_slt     <= w_slt;
                r_illegal <= ~w_legal;
            end
            if (w_lo) begin
                r_res[HALF-1:0] <= alu_result;
                r_cout_lo       <= alu_cout;
                r_zero_lo       <= alu_zero;
            end
            if (w_hi) begin
                r_res[2*HALF-1:HALF] <= alu_result;
                r_cout               <= alu_cout;
                r_ovf                <= alu_overflow;
                r_zero_hi            <= alu_zero;
            end
        end
    end

    // next state; a DONE handshake may accept the following request on the same edge
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = w_legal ? S_LO : S_DONE;
            S_LO:    w_next = S_HI;
            S_HI:    w_next = S_DONE;
            S_DONE:  if (resp_ready) w_next = !req_valid ? S_IDLE : (w_legal ? S_LO : S_DONE);
            default: w_next = S_IDLE;
        endcase
    end

    // ALU drive and response outputs, all zero outside their owning states
    always_comb begin
        w_lo         = (r_state == S_LO);
        w_hi         = (r_state == S_HI);
        w_done       = (r_state == S_DONE);
        req_ready    = rst_n & ((r_state == S_IDLE) | (w_done & resp_ready));
        w_req_hs     = req_valid & req_ready;
        alu_a        = w_lo ? r_a[HALF-1:0] : (w_hi ? r_a[2*HALF-1:HALF] : '0);
        alu_b        = w_lo ? r_b[HALF-1:0] : (w_hi ? r_b[2*HALF-1:HALF] : '0);
        alu_cin      = w_lo ? r_cin0 : (w_hi & r_cout_lo);
        alu_op       = (w_lo | w_hi) ? r_alu_op : 3'b000;
        alu_less     = 1'b0;
        w_slt_bit    = r_res[2*HALF-1] ^ r_ovf;
        resp_valid   = w_done;
        resp_result  = (!w_done || r_illegal) ? '0 : (r_slt ? {{(2*HALF-1){1'b0}}, w_slt_bit} : r_res);
        resp_zero    = w_done & ~r_illegal & (r_slt ? ~w_slt_bit : (r_zero_lo & r_zero_hi));
        resp_cout    = w_done & r_arith & r_cout;
        resp_ovf     = w_done & r_arith & r_ovf;
        resp_illegal = w_done & r_illegal;
    end

`ifdef ALU_SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] r_cnt;
    // count completed response handshakes, wrapping naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else if (resp_valid & resp_ready) r_cnt <= r_cnt + 1'b1;
    end
    assign op_count = r_cnt;
`else
    assign op_count = '0;
`endif
endmodule

// File: tb/tb_alu32_seq_ctrl.sv
// tb_alu32_seq_ctrl: directed checks of alu32_seq_ctrl against a behavioural 16-bit ALU
module tb_alu32_seq_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b0;
    logic [2:0]  req_op = '0, alu_op;
    logic [31:0] req_a = '0, req_b = '0, resp_result;
    logic [15:0] alu_a, alu_b, m_res, m_bb;
    logic [16:0] m_sum;
    logic        alu_cin, alu_less, m_cout, m_zero, m_ovf;
    logic        resp_cout, resp_zero, resp_ovf, resp_illegal;
    logic [15:0] op_count;
    int          n_checks = 0, n_fail = 0, n_resp = 0;

    always #5 clk = ~clk;

    alu32_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_less(alu_less), .alu_op(alu_op),
        .alu_result(m_res), .alu_cout(m_cout), .alu_zero(m_zero), .alu_overflow(m_ovf),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_cout(resp_cout), .resp_zero(resp_zero), .resp_ovf(resp_ovf),
        .resp_illegal(resp_illegal), .op_count(op_count)
    );

    // behavioural 16-bit ALU: AND, OR, ADD (010), SUB (110 = a + ~b + cin)
    always_comb begin
        m_bb   = alu_op[2] ? ~alu_b : alu_b;
        m_sum  = {1'b0, alu_a} + {1'b0, m_bb} + {16'b0, alu_cin};
        m_res  = (alu_op == 3'b000) ? (alu_a & alu_b) : (alu_op == 3'b001) ? (alu_a | alu_b) : m_sum[15:0];
        m_cout = alu_op[1] & m_sum[16];
        m_ovf  = alu_op[1] & (alu_a[15] == m_bb[15]) & (m_sum[15] != alu_a[15]);
        m_zero = (m_res == 16'h0);
    end

    // lat counts edges from the cycle the request is presented (accept edge = 1)
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [2:0] lo_op, output logic lo_cin);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; lat = 1; lo_op = alu_op; lo_cin = alu_cin;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic take_resp();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0; n_resp++;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
        n_checks++; if ({resp_valid, resp_result, alu_a, alu_b, alu_op} !== '0) begin n_fail++; $display("FAIL rst_outputs valid %b res %h alu_a %h", resp_valid, resp_result, alu_a); end
        @(posedge clk); #1; rst_n = 1'b1; #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_req_ready got %b want 1", req_ready); end
        n_checks++; if (op_count !== 16'h0) begin n_fail++; $display("FAIL rst_count got %h want 0", op_count); end
    endtask

    task automatic test_add();
        int lat; logic [2:0] lo; logic ci;
        run_op(3'b010, 32'h0000FFFF, 32'h00000001, lat, lo, ci);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL add_latency got %0d want 3", lat); end
        n_checks++; if (lo !== 3'b010 || ci !== 1'b0) begin n_fail++; $display("FAIL add_lo_drive op %b cin %b want 010 0", lo, ci); end
        n_checks++; if (resp_result !== 32'h00010000) begin n_fail++; $display("FAIL add_result got %h want 00010000", resp_result); end
        n_checks++; if ({resp_cout, resp_ovf, resp_zero, resp_illegal} !== 4'b0000) begin n_fail++; $display("FAIL add_flags got %b want 0000", {resp_cout, resp_ovf, resp_zero, resp_illegal}); end
        n_checks++; if ({alu_a, alu_b, alu_op, alu_cin, alu_less} !== '0) begin n_fail++; $display("FAIL done_alu_idle alu_a %h alu_b %h", alu_a, alu_b); end
        take_resp();
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL add_release valid %b ready %b want 0 1", resp_valid, req_ready); end
    endtask

    task automatic test_sub();
        int lat; logic [2:0] lo; logic ci;
        run_op(3'b110, 32'h80000000, 32'h00000001, lat, lo, ci);
        n_checks++; if (lo !== 3'b110 || ci !== 1'b1) begin n_fail++; $display("FAIL sub_lo_drive op %b cin %b want 110 1", lo, ci); end
        n_checks++; if (resp_result !== 32'h7FFFFFFF) begin n_fail++; $display("FAIL sub_ovf_result got %h want 7fffffff", resp_result); end
        n_checks++; if ({resp_cout, resp_ovf, resp_zero} !== 3'b110) begin n_fail++; $display("FAIL sub_ovf_flags cout/ovf/zero got %b want 110", {resp_cout, resp_ovf, resp_zero}); end
        take_resp();
        run_op(3'b110, 32'd5, 32'd5, lat, lo, ci);
        n_checks++; if (resp_result !== 32'h0) begin n_fail++; $display("FAIL sub_eq_result got %h want 0", resp_result); end
        n_checks++; if ({resp_cout, resp_ovf, resp_zero} !== 3'b101) begin n_fail++; $display("FAIL sub_eq_flags cout/ovf/zero got %b want 101", {resp_cout, resp_ovf, resp_zero}); end
        take_resp();
    endtask

    task automatic test_slt();
        int lat; logic [2:0] lo; logic ci;
        run_op(3'b111, 32'hFFFFFFFE, 32'h00000001, lat, lo, ci);
        n_checks++; if (lo !== 3'b110 || ci !== 1'b1) begin n_fail++; $display("FAIL slt_as_sub op %b cin %b want 110 1", lo, ci); end
        n_checks++; if (resp_result !== 32'h1) begin n_fail++; $display("FAIL slt_neg_result got %h want 1", resp_result); end
        n_checks++; if ({resp_cout, resp_ovf, resp_zero} !== 3'b000) begin n_fail++; $display("FAIL slt_neg_flags got %b want 000", {resp_cout, resp_ovf, resp_zero}); end
        take_resp();
        run_op(3'b111, 32'h00000001, 32'hFFFFFFFE, lat, lo, ci);
        n_checks++; if (resp_result !== 32'h0) begin n_fail++; $display("FAIL slt_pos_result got %h want 0", resp_result); end
        n_checks++; if ({resp_cout, resp_ovf, resp_zero} !== 3'b001) begin n_fail++; $display("FAIL slt_pos_flags got %b want 001", {resp_cout, resp_ovf, resp_zero}); end
        take_resp();
    endtask

    task automatic test_logic();
        int lat; logic [2:0] lo; logic ci;
        run_op(3'b000, 32'hF0F0F0F0, 32'hFF00FF00, lat, lo, ci);
        n_checks++; if (resp_result !== 32'hF000F000 || resp_zero !== 1'b0) begin n_fail++; $display("FAIL and_result got %h z %b want f000f000 0", resp_result, resp_zero); end
        take_resp();
        run_op(3'b000, 32'hFFFF0000, 32'h0000FFFF, lat, lo, ci);
        n_checks++; if (resp_result !== 32'h0 || {resp_zero, resp_cout, resp_ovf} !== 3'b100) begin n_fail++; $display("FAIL and_zero got %h flags %b want 0 100", resp_result, {resp_zero, resp_cout, resp_ovf}); end
        take_resp();
        run_op(3'b001, 32'h12340000, 32'h00005678, lat, lo, ci);
        n_checks++; if (resp_result !== 32'h12345678 || lo !== 3'b001) begin n_fail++; $display("FAIL or_result got %h op %b want 12345678 001", resp_result, lo); end
        take_resp();
    endtask

    task automatic test_illegal();
        int lat; logic [2:0] lo; logic ci;
        run_op(3'b011, 32'hDEADBEEF, 32'h12345678, lat, lo, ci);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL illegal_latency got %0d want 1", lat); end
        n_checks++; if (resp_result !== 32'h0 || {resp_illegal, resp_cout, resp_ovf, resp_zero} !== 4'b1000) begin n_fail++; $display("FAIL illegal_resp got %h flags %b want 0 1000", resp_result, {resp_illegal, resp_cout, resp_ovf, resp_zero}); end
        n_checks++; if (lo !== 3'b000 || alu_a !== 16'h0) begin n_fail++; $display("FAIL illegal_no_alu op %b alu_a %h want 000 0", lo, alu_a); end
        take_resp();
    endtask

    task automatic test_back_to_back();
        int lat; logic [2:0] lo; logic ci; int bad = 0;
        run_op(3'b010, 32'd1, 32'd2, lat, lo, ci);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || resp_result !== 32'd3 || req_ready !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL stall_stable bad cycles %0d want 0 (valid %b res %h ready %b)", bad, resp_valid, resp_result, req_ready); end
        resp_ready = 1'b1; req_valid = 1'b1; req_op = 3'b010; req_a = 32'd10; req_b = 32'd20; #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_req_ready got %b want 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0; resp_ready = 1'b0; n_resp++; lat = 1;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drop_valid got %b want 0", resp_valid); end
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        n_checks++; if (lat !== 3 || resp_result !== 32'd30) begin n_fail++; $display("FAIL b2b_second lat %0d res %h want 3 0000001e", lat, resp_result); end
        take_resp();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        req_valid = 1'b1; req_op = 3'b010; req_a = 32'h12345678; req_b = 32'h00010001;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (alu_a !== 16'h1234 || alu_b !== 16'h0001) begin n_fail++; $display("FAIL hi_drive alu_a %h alu_b %h want 1234 0001", alu_a, alu_b); end
        rst_n = 1'b0; #1;
        n_checks++; if ({req_ready, resp_valid, resp_result, alu_a, alu_b, alu_cin, alu_op, op_count} !== '0) begin n_fail++; $display("FAIL mid_rst_outputs ready %b valid %b alu_a %h cnt %h", req_ready, resp_valid, alu_a, op_count); end
        n_resp = 0;
        @(posedge clk); #1; rst_n = 1'b1; resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (resp_valid) seen++; end
        resp_ready = 1'b0;
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL mid_rst_no_resp saw %0d responses want 0", seen); end
    endtask

    task automatic test_counter();
        int lat; logic [2:0] lo; logic ci; logic [15:0] exp_cnt;
        for (int i = 0; i < 3; i++) begin run_op(3'b010, i, 32'd1, lat, lo, ci); take_resp(); end
`ifdef ALU_SEQ_PERF_CNT_EN
        exp_cnt = n_resp[15:0];
`else
        exp_cnt = 16'h0;
`endif
        n_checks++; if (op_count !== exp_cnt) begin n_fail++; $display("FAIL op_count got %0d want %0d", op_count, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_counter();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
